// File: rtl/pcie_dma_mwr_gen_if.sv
// pcie_dma_mwr_gen_if: slave register bus, TLP engine master bus and status lines
`timescale 1ns/1ps
interface pcie_dma_mwr_gen_if;
  logic [6:0]  slv_bar_i;
  logic        slv_ce_i;
  logic        slv_we_i;
  logic [19:1] slv_adr_i;
  logic [15:0] slv_dat_i;
  logic [1:0]  slv_sel_i;
  logic [15:0] slv_dat_o;
  logic        mst_req_o;
  logic        mst_rdy_i;
  logic        mst_st_i;
  logic        mst_ce_i;
  logic [15:0] mst_dat_o;
  logic        busy_o;
  logic        done_o;
  modport slave (
    input  slv_bar_i, slv_ce_i, slv_we_i, slv_adr_i, slv_dat_i, slv_sel_i, mst_rdy_i, mst_st_i, mst_ce_i,
    output slv_dat_o, mst_req_o, mst_dat_o, busy_o, done_o
  );
  modport master (
    output slv_bar_i, slv_ce_i, slv_we_i, slv_adr_i, slv_dat_i, slv_sel_i, mst_rdy_i, mst_st_i, mst_ce_i,
    input  slv_dat_o, mst_req_o, mst_dat_o, busy_o, done_o
  );
endinterface

// File: rtl/pcie_dma_mwr_gen.sv
// pcie_dma_mwr_gen: splits a DMA descriptor into 3DW MWr TLPs with an incrementing 16-bit payload
`timescale 1ns/1ps
module pcie_dma_mwr_gen #(
  parameter int         MAX_PAYLOAD_DW = 32,
  parameter logic [7:0] TAG_BASE       = 8'h00
) (
  input logic               pcie_clk,
  input logic               sys_rst,
  input logic [7:0]         bus_num,
  input logic [4:0]         dev_num,
  input logic [2:0]         func_num,
  pcie_dma_mwr_gen_if.slave bus
);
  typedef enum logic [2:0] {IDLE, CALC, REQ, XFER, NEXT} state_t;
  state_t state, state_n;
  logic [31:2] addr_reg;
  logic [31:0] waddr;
  logic [15:0] len_reg, seed_reg, tlpcnt, rem, pat, rdata, word, edge_dw, lim, blen_calc, lo_m;
  logic [7:0]  tag, blen;
  logic [8:0]  widx, cur, nxt, off;
  logic done, aborted, abort_pend;
  logic acc, wr, ctrl_wr, start, abort, clr, abrt, idle, start_go, last_ce, fin, req_abort;
  logic unused_ok;

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d, input logic [1:0] s);
    return {s[1] ? d[15:8] : old[15:8], s[0] ? d[7:0] : old[7:0]};
  endfunction

  assign acc       = bus.slv_bar_i[0] & bus.slv_ce_i;
  assign wr        = acc & bus.slv_we_i;
  assign off       = bus.slv_adr_i[9:1];
  assign ctrl_wr   = wr & (off == 9'h013) & bus.slv_sel_i[0];
  assign start     = ctrl_wr & bus.slv_dat_i[0];
  assign abort     = ctrl_wr & bus.slv_dat_i[1];
  assign clr       = ctrl_wr & bus.slv_dat_i[2];
  assign idle      = state == IDLE;
  assign abrt      = abort | abort_pend;
  assign start_go  = start & idle & (len_reg != 16'd0);
  assign cur       = bus.mst_st_i ? 9'd0 : widx;
  assign nxt       = cur + 9'd1;
  assign last_ce   = (state == XFER) & bus.mst_ce_i & (cur == 9'd5 + {blen, 1'b0});
  assign fin       = (state == NEXT) & ((rem == {8'd0, blen}) | abrt);
  assign req_abort = (state == REQ) & ~bus.mst_rdy_i & abrt;
  // DWORDs left before the next 4 KB boundary
  assign edge_dw   = (16'd4096 - {4'd0, waddr[11:0]}) >> 2;
  assign lim       = rem < 16'(MAX_PAYLOAD_DW) ? rem : 16'(MAX_PAYLOAD_DW);
  assign blen_calc = lim < edge_dw ? lim : edge_dw;
  assign lo_m      = merge({addr_reg[15:2], 2'b00}, bus.slv_dat_i, bus.slv_sel_i);
  assign unused_ok = ^{bus.slv_bar_i[6:1], bus.slv_adr_i[19:10], blen_calc[15:8], lo_m[1:0]};

  // word presented after the consume strobe; payload continues from pat
  assign word = (nxt == 9'd1) ? {8'd0, blen} :
                (nxt == 9'd2) ? {bus_num, dev_num, func_num} :
                (nxt == 9'd3) ? {tag, (blen > 8'd1) ? 4'hF : 4'h0, 4'hF} :
                (nxt == 9'd4) ? waddr[31:16] :
                (nxt == 9'd5) ? {waddr[15:2], 2'b00} :
                pat + {7'd0, nxt} - 16'd6;

  assign rdata = (off == 9'h010) ? {addr_reg[15:2], 2'b00} :
                 (off == 9'h011) ? addr_reg[31:16] :
                 (off == 9'h012) ? len_reg :
                 (off == 9'h013) ? {13'd0, aborted, done, ~idle} :
                 (off == 9'h014) ? seed_reg :
                 (off == 9'h015) ? tlpcnt : 16'd0;

  assign bus.mst_req_o = state == REQ;
  assign bus.busy_o    = ~idle;
  assign bus.done_o    = done;

  always_ff @(posedge pcie_clk or posedge sys_rst)
    if (sys_rst) state <= IDLE;
    else state <= state_n;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start_go ? CALC : IDLE;
      CALC:    state_n = REQ;
      REQ:     state_n = bus.mst_rdy_i ? XFER : (abrt ? IDLE : REQ);
      XFER:    state_n = last_ce ? NEXT : XFER;
      NEXT:    state_n = fin ? IDLE : CALC;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge pcie_clk or posedge sys_rst) begin
    if (sys_rst) begin
      addr_reg      <= '0;
      len_reg       <= '0;
      seed_reg      <= '0;
      tlpcnt        <= '0;
      rem           <= '0;
      pat           <= '0;
      waddr         <= '0;
      tag           <= TAG_BASE;
      blen          <= '0;
      widx          <= '0;
      done          <= 1'b0;
      aborted       <= 1'b0;
      abort_pend    <= 1'b0;
      bus.slv_dat_o <= '0;
      bus.mst_dat_o <= '0;
    end else begin
      if (acc & ~bus.slv_we_i) bus.slv_dat_o <= rdata;
      if (wr & idle) begin
        if (off == 9'h010) addr_reg[15:2] <= lo_m[15:2];
        if (off == 9'h011) addr_reg[31:16] <= merge(addr_reg[31:16], bus.slv_dat_i, bus.slv_sel_i);
        if (off == 9'h012) len_reg <= merge(len_reg, bus.slv_dat_i, bus.slv_sel_i);
        if (off == 9'h014) seed_reg <= merge(seed_reg, bus.slv_dat_i, bus.slv_sel_i);
      end
      // a clear in the same write as a start wins over the zero-length done
      done <= (fin | req_abort) ? 1'b1 : (start & idle) ? (len_reg == 16'd0) & ~clr : clr ? 1'b0 : done;
      if (abort & ~idle) abort_pend <= 1'b1;
      if (start_go) begin
        waddr      <= {addr_reg, 2'b00};
        rem        <= len_reg;
        pat        <= seed_reg;
        tlpcnt     <= '0;
        aborted    <= 1'b0;
        abort_pend <= 1'b0;
      end
      if (state == CALC) begin
        blen          <= blen_calc[7:0];
        bus.mst_dat_o <= 16'h4000;
        widx          <= '0;
      end
      if ((state == XFER) & bus.mst_ce_i) begin
        widx          <= nxt;
        bus.mst_dat_o <= word;
      end
      if (state == NEXT) begin
        waddr  <= waddr + {22'd0, blen, 2'b00};
        rem    <= rem - {8'd0, blen};
        pat    <= pat + {7'd0, blen, 1'b0};
        tag    <= tag + 8'd1;
        tlpcnt <= tlpcnt + 16'd1;
      end
      if (fin) begin
        aborted    <= abrt;
        abort_pend <= 1'b0;
      end
      if (req_abort) begin
        aborted    <= 1'b1;
        abort_pend <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_pcie_dma_mwr_gen.sv
// tb_pcie_dma_mwr_gen: random-delay engine, scoreboard monitor and descriptor-level reference model
`timescale 1ns/1ps
module tb_pcie_dma_mwr_gen;
  localparam int         MAX_PAYLOAD_DW = 32;
  localparam logic [7:0] TAG_BASE       = 8'h00;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] bus_num  = 8'h5A;
  logic [4:0] dev_num  = 5'h13;
  logic [2:0] func_num = 3'h5;
  pcie_dma_mwr_gen_if bus();

  pcie_dma_mwr_gen #(.MAX_PAYLOAD_DW(MAX_PAYLOAD_DW), .TAG_BASE(TAG_BASE)) dut (
    .pcie_clk(clk), .sys_rst(rst), .bus_num(bus_num), .dev_num(dev_num), .func_num(func_num), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0, words_seen = 0;
  logic [15:0] exp_q[$];
  int len_q[$];
  logic [7:0] exp_tag = TAG_BASE;
  bit eng_en = 1'b1, flush = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // scoreboard monitor: every consumed word is compared with the next expected one
  always @(negedge clk)
    if (!flush && bus.mst_ce_i) begin
      words_seen++;
      if (exp_q.size() == 0) chk("extra_word", {16'd0, bus.mst_dat_o}, 32'hFFFF_FFFF);
      else chk("tlp_word", {16'd0, bus.mst_dat_o}, {16'd0, exp_q.pop_front()});
    end

  // engine: grants after a random delay, then consumes the expected word count with random gaps
  initial begin
    int n, i;
    bus.mst_rdy_i = 1'b0;
    bus.mst_st_i  = 1'b0;
    bus.mst_ce_i  = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (eng_en && !flush && bus.mst_req_o) begin
        if (len_q.size() == 0) begin
          chk("unexpected_req", 32'(bus.mst_req_o), 32'd0);
          for (int k = 0; k < 200 && bus.mst_req_o; k++) begin @(posedge clk); #1; end
        end else begin
          n = len_q.pop_front();
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          bus.mst_rdy_i = 1'b1;
          @(posedge clk); #1;
          bus.mst_rdy_i = 1'b0;
          i = 0;
          while (i < n && !flush) begin
            if ($urandom_range(0, 3) != 0) begin
              bus.mst_ce_i = 1'b1;
              bus.mst_st_i = (i == 0);
              i++;
            end else begin
              bus.mst_ce_i = 1'b0;
              bus.mst_st_i = 1'b0;
            end
            @(posedge clk); #1;
          end
          bus.mst_ce_i = 1'b0;
          bus.mst_st_i = 1'b0;
        end
      end
    end
  end

  task automatic wr_reg(input logic [8:0] off, input logic [15:0] d, input logic [1:0] s);
    @(posedge clk); #1;
    bus.slv_bar_i = 7'd1; bus.slv_ce_i = 1'b1; bus.slv_we_i = 1'b1;
    bus.slv_adr_i = {10'd0, off}; bus.slv_dat_i = d; bus.slv_sel_i = s;
    @(posedge clk); #1;
    bus.slv_bar_i = 7'd0; bus.slv_ce_i = 1'b0; bus.slv_we_i = 1'b0;
  endtask

  task automatic rd_reg(input logic [8:0] off, output logic [15:0] d);
    @(posedge clk); #1;
    bus.slv_bar_i = 7'd1; bus.slv_ce_i = 1'b1; bus.slv_we_i = 1'b0; bus.slv_adr_i = {10'd0, off};
    @(posedge clk); #1;
    bus.slv_bar_i = 7'd0; bus.slv_ce_i = 1'b0;
    d = bus.slv_dat_o;
  endtask

  task automatic prog(input logic [31:0] a, input logic [15:0] l, input logic [15:0] s);
    wr_reg(9'h010, a[15:0], 2'b11);
    wr_reg(9'h011, a[31:16], 2'b11);
    wr_reg(9'h012, l, 2'b11);
    wr_reg(9'h014, s, 2'b11);
  endtask

  // reference model: walk the descriptor TLP by TLP and queue every expected word
  task automatic plan(input logic [31:0] addr, input logic [15:0] len, input logic [15:0] seed,
                      input int max_tlps, output int ntlp);
    logic [31:0] a;
    logic [15:0] p;
    int rem, b, room;
    a = {addr[31:2], 2'b00}; rem = int'(len); p = seed; ntlp = 0;
    while (rem > 0 && ntlp < max_tlps) begin
      room = (4096 - int'(a % 32'd4096)) / 4;
      b = rem;
      if (b > MAX_PAYLOAD_DW) b = MAX_PAYLOAD_DW;
      if (b > room) b = room;
      exp_q.push_back(16'h4000);
      exp_q.push_back(16'(b));
      exp_q.push_back({bus_num, dev_num, func_num});
      exp_q.push_back({exp_tag, (b > 1) ? 4'hF : 4'h0, 4'hF});
      exp_q.push_back(a[31:16]);
      exp_q.push_back(a[15:0]);
      for (int k = 0; k < 2 * b; k++) begin exp_q.push_back(p); p++; end
      len_q.push_back(6 + 2 * b);
      a += 32'(4 * b); rem -= b; exp_tag++; ntlp++;
    end
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (!bus.done_o && k < 5000) begin @(posedge clk); #1; k++; end
    chk(name, 32'(bus.done_o), 32'd1);
  endtask

  task automatic run(input string name, input logic [31:0] a, input logic [15:0] l, input logic [15:0] s,
                     input bit busy_wr);
    int n;
    logic [15:0] r;
    prog(a, l, s);
    plan(a, l, s, 1000, n);
    wr_reg(9'h013, 16'h0001, 2'b11);
    if (busy_wr) wr_reg(9'h012, ~l, 2'b11);
    wait_done({name, "_done"});
    repeat (2) @(posedge clk);
    #1;
    chk({name, "_drain"}, exp_q.size(), 32'd0);
    rd_reg(9'h015, r); chk({name, "_tlpcnt"}, {16'd0, r}, n);
    rd_reg(9'h013, r); chk({name, "_ctrl"}, {16'd0, r}, 32'h0002);
    if (busy_wr) begin rd_reg(9'h012, r); chk({name, "_len_locked"}, {16'd0, r}, {16'd0, l}); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] r;
    logic [31:0] a;
    int n;
    bit seen;
    bus.slv_bar_i = '0; bus.slv_ce_i = 1'b0; bus.slv_we_i = 1'b0;
    bus.slv_adr_i = '0; bus.slv_dat_i = '0; bus.slv_sel_i = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_req_busy_done", {29'd0, bus.mst_req_o, bus.busy_o, bus.done_o}, 32'd0);
    chk("rst_mst_dat", {16'd0, bus.mst_dat_o}, 32'd0);
    chk("rst_slv_dat", {16'd0, bus.slv_dat_o}, 32'd0);
    rd_reg(9'h013, r); chk("rst_ctrl", {16'd0, r}, 32'd0);
    rd_reg(9'h015, r); chk("rst_tlpcnt", {16'd0, r}, 32'd0);
    wr_reg(9'h010, 16'h1237, 2'b11);
    rd_reg(9'h010, r); chk("addr_lo_mask", {16'd0, r}, 32'h1234);
    wr_reg(9'h011, 16'hABCD, 2'b10);
    rd_reg(9'h011, r); chk("addr_hi_sel", {16'd0, r}, 32'hAB00);
    rd_reg(9'h016, r); chk("unmapped", {16'd0, r}, 32'd0);

    run("single", 32'h0000_1000, 16'd4, 16'h1234, 1'b0);
    run("edge4k", 32'h0000_0FF8, 16'd40, 16'hBEEF, 1'b0);
    run("len1", 32'h0000_2000, 16'd1, 16'h0042, 1'b0);

    wr_reg(9'h013, 16'h0004, 2'b11);
    chk("clear_done", 32'(bus.done_o), 32'd0);
    prog(32'h0000_3000, 16'd0, 16'h0000);
    wr_reg(9'h013, 16'h0001, 2'b11);
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin seen |= bus.mst_req_o; @(posedge clk); #1; end
    chk("len0_no_req", 32'(seen), 32'd0);
    chk("len0_done", {30'd0, bus.busy_o, bus.done_o}, 32'd1);
    wr_reg(9'h013, 16'h0005, 2'b11);
    chk("start_clear_done", 32'(bus.done_o), 32'd0);

    eng_en = 1'b0;
    prog(32'h0000_4000, 16'd8, 16'h0001);
    wr_reg(9'h013, 16'h0001, 2'b11);
    for (int k = 0; k < 50 && !bus.mst_req_o; k++) begin @(posedge clk); #1; end
    chk("req_raised", 32'(bus.mst_req_o), 32'd1);
    wr_reg(9'h013, 16'h0002, 2'b11);
    chk("abort_req_drop", 32'(bus.mst_req_o), 32'd0);
    rd_reg(9'h013, r); chk("abort_req_ctrl", {16'd0, r}, 32'h0006);
    eng_en = 1'b1;

    prog(32'h0000_5000, 16'd64, 16'h7700);
    plan(32'h0000_5000, 16'd64, 16'h7700, 1, n);
    words_seen = 0;
    wr_reg(9'h013, 16'h0001, 2'b11);
    for (int k = 0; k < 2000 && words_seen < 8; k++) begin @(posedge clk); #1; end
    wr_reg(9'h013, 16'h0002, 2'b11);
    wait_done("abort_xfer_done");
    repeat (20) @(posedge clk);
    #1;
    chk("abort_xfer_drain", exp_q.size(), 32'd0);
    chk("abort_xfer_req", 32'(bus.mst_req_o), 32'd0);
    rd_reg(9'h015, r); chk("abort_xfer_tlpcnt", {16'd0, r}, 32'd1);
    rd_reg(9'h013, r); chk("abort_xfer_ctrl", {16'd0, r}, 32'h0006);

    for (int it = 0; it < 6; it++) begin
      a = $urandom;
      if (it % 2 == 0) a[11:0] = 12'($urandom_range(3800, 4095));
      run("rand", a, 16'($urandom_range(1, 150)), 16'($urandom), it == 0);
    end

    prog(32'h0000_6000, 16'd64, 16'h1111);
    plan(32'h0000_6000, 16'd64, 16'h1111, 1, n);
    words_seen = 0;
    wr_reg(9'h013, 16'h0001, 2'b11);
    for (int k = 0; k < 2000 && words_seen < 10; k++) begin @(posedge clk); #1; end
    @(posedge clk);
    #3 flush = 1'b1;
    rst = 1'b1;
    #1;
    chk("midrst_req_busy_done", {29'd0, bus.mst_req_o, bus.busy_o, bus.done_o}, 32'd0);
    chk("midrst_mst_dat", {16'd0, bus.mst_dat_o}, 32'd0);
    chk("midrst_slv_dat", {16'd0, bus.slv_dat_o}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    len_q.delete();
    exp_tag = TAG_BASE;
    repeat (3) @(posedge clk);
    #1 flush = 1'b0;
    run("post_rst", 32'h0000_7FF0, 16'd20, 16'hCAFE, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
